// File: rtl/diag_seq.sv
// diag_seq: EBUS diag function sequencer (SETUP/ACTIVE/HOLD/RSP); DIAG_SEQ_PARITY_EN adds odd-parity check on read data.
// Strobe lands SETUP_CYC+1 edges after accept; cmd_ready only in IDLE, read response held until rsp_ready.
module diag_seq #(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 4,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_read,
  input  logic [0:6]  cmd_ds,
  output logic [0:6]  ds,
  output logic        diag_strobe,
  output logic        diag_read,
  output logic        DIAG_CTL_FUNC_01x,
  output logic        DIAG_READ_FUNC_13x,
  input  logic [0:35] ebus_data,
  input  logic        ebus_parity,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [0:35] rsp_data,
  output logic        rsp_par_err,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACTIVE = 3'd2,
    HOLD   = 3'd3,
    RSP    = 3'd4
  } state_e;

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD   = (HOLD_CYC != 0) ? 4'(HOLD_CYC - 1) : 4'd0;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [0:6]  ds_q, ds_d;
  logic        rd_q, rd_d;
  logic        strobe_q, strobe_d;
  logic        read_q, read_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        busy_q, busy_d;
  logic [0:35] rsp_data_q, rsp_data_d;
  logic        cap_en;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ds_d       = ds_q;
    rd_d       = rd_q;
    cap_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = SETUP;
          cnt_d   = SETUP_LD;
          ds_d    = cmd_ds;
          rd_d    = cmd_read;
        end
      end
      SETUP: begin
        if (cnt_q == 4'd0) begin
          state_d = ACTIVE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACTIVE: begin
        if (cnt_q == 4'd0) begin
          cap_en = rd_q;
          if (HOLD_CYC != 0) begin
            state_d = HOLD;
            cnt_d   = HOLD_LD;
          end else begin
            state_d = rd_q ? RSP : IDLE;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d = rd_q ? RSP : IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Enables are decoded from the next state so they come straight off flops.
    strobe_d    = (state_d == ACTIVE) && !rd_d;
    read_d      = (state_d == ACTIVE) && rd_d;
    rsp_valid_d = (state_d == RSP);
    busy_d      = (state_d != IDLE);
    rsp_data_d  = cap_en ? ebus_data : rsp_data_q;
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      ds_q        <= 7'd0;
      rd_q        <= 1'b0;
      strobe_q    <= 1'b0;
      read_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      rsp_data_q  <= 36'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ds_q        <= ds_d;
      rd_q        <= rd_d;
      strobe_q    <= strobe_d;
      read_q      <= read_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

`ifdef DIAG_SEQ_PARITY_EN
  logic par_err_q, par_err_d;

  // Odd parity: an even count of ones across data plus parity is an error.
  always_comb begin
    par_err_d = cap_en ? ~((^ebus_data) ^ ebus_parity) : par_err_q;
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end

  assign rsp_par_err = par_err_q;
`else
  logic unused_parity;
  assign unused_parity = ebus_parity;
  assign rsp_par_err   = 1'b0;
`endif

  // RESET gates cmd_ready directly so no command can be offered as accepted during reset.
  assign cmd_ready          = (state_q == IDLE) && !RESET;
  assign ds                 = ds_q;
  assign diag_strobe        = strobe_q;
  assign diag_read          = read_q;
  assign DIAG_CTL_FUNC_01x  = strobe_q && (ds_q[0:3] == 4'b0001);
  assign DIAG_READ_FUNC_13x = read_q && (ds_q[0:3] == 4'b1011);
  assign rsp_valid          = rsp_valid_q;
  assign rsp_data           = rsp_data_q;
  assign busy               = busy_q;

endmodule
